// File: rtl/bus_arb.sv
// Arbitrates the hart's instruction-fill and data buses onto one line-wide
// memory port, with a per-transaction ack timeout and a sticky error flag.
module bus_arb #(
  parameter int ADDR_W  = 64,
  parameter int LINE_W  = 1024,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic              b_rd_i,
  output logic [LINE_W-1:0] b_data_i,
  output logic              b_dv_i,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_rd,
  input  logic              b_wr,
  input  logic [LINE_W-1:0] b_data_out,
  output logic [LINE_W-1:0] b_data_in,
  output logic              b_dv,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    RESP
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_LAST);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(127);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_i_q, last_i_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic              m_rd_d, m_wr_d;
  logic [LINE_W-1:0] m_wdata_d;
  logic [LINE_W-1:0] b_data_i_d, b_data_in_d;
  logic              b_dv_i_d, b_dv_d;
  logic              err_d;
  logic              tmo;
  logic              fin;

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_i_q  <= 1'b0;
      m_addr    <= '0;
      m_rd      <= 1'b0;
      m_wr      <= 1'b0;
      m_wdata   <= '0;
      b_data_i  <= '0;
      b_data_in <= '0;
      b_dv_i    <= 1'b0;
      b_dv      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_i_q  <= last_i_d;
      m_addr    <= m_addr_d;
      m_rd      <= m_rd_d;
      m_wr      <= m_wr_d;
      m_wdata   <= m_wdata_d;
      b_data_i  <= b_data_i_d;
      b_data_in <= b_data_in_d;
      b_dv_i    <= b_dv_i_d;
      b_dv      <= b_dv_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_i_d    = last_i_q;
    m_addr_d    = m_addr;
    m_rd_d      = m_rd;
    m_wr_d      = m_wr;
    m_wdata_d   = m_wdata;
    b_data_i_d  = b_data_i;
    b_data_in_d = b_data_in;
    b_dv_i_d    = 1'b0;
    b_dv_d      = 1'b0;
    err_d       = err;
    tmo         = (TIMEOUT > 0) && (cnt_q == CNT_MAX);
    fin         = m_ack || tmo;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (b_wr) begin
          state_d   = D_WR;
          m_wr_d    = 1'b1;
          m_addr_d  = b_addr & LINE_MASK;
          m_wdata_d = b_data_out;
        end else if (b_rd && (!b_rd_i || last_i_q)) begin
          state_d  = D_RD;
          m_rd_d   = 1'b1;
          m_addr_d = b_addr & LINE_MASK;
          last_i_d = 1'b0;
        end else if (b_rd_i) begin
          state_d  = I_RD;
          m_rd_d   = 1'b1;
          m_addr_d = b_addr_i & LINE_MASK;
          last_i_d = 1'b1;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (fin) begin
          state_d  = RESP;
          m_rd_d   = 1'b0;
          m_wr_d   = 1'b0;
          b_dv_i_d = (state_q == I_RD);
          b_dv_d   = (state_q != I_RD);
          // ack wins over a coincident timeout; a timed-out read returns zeros
          if (!m_ack) err_d = 1'b1;
          if (state_q == I_RD)
            b_data_i_d = m_ack ? m_rdata : '0;
          if (state_q == D_RD)
            b_data_in_d = m_ack ? m_rdata : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
